// File: rtl/bank_loader.sv
// Streams words from a valid/ready source into ram_num RAM banks, round-robin by bank, then by address.
// Optional sticky stray-data flag (ovf) is built only when BANK_LOADER_OVF_EN is defined.
module bank_loader #(
    parameter int unsigned ram_num = 10,
    parameter int unsigned width   = 16,
    parameter int unsigned address = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [address:0]     fill_len,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [width-1:0]     s_data,
    output logic [ram_num-1:0]   ena,
    output logic [ram_num-1:0]   wea,
    output logic [address-1:0]   addra [0:ram_num-1],
    output logic [width-1:0]     dina  [0:ram_num-1],
    output logic                 busy,
    output logic                 done,
    output logic                 ovf
);
    localparam int unsigned BankW = (ram_num > 1) ? $clog2(ram_num) : 1;
    localparam int unsigned LenW  = address + 1;

    typedef enum logic [1:0] {StIdle, StLoad, StDone} state_e;

    state_e              state_q, state_d;
    logic [LenW-1:0]     len_q, len_d;
    logic [BankW-1:0]    bank_q, bank_d;
    logic [address-1:0]  addr_q, addr_d;
    logic [ram_num-1:0]  wen_q;
    logic                hs;
    logic                bank_wrap;
    logic                last;

    assign s_ready   = (state_q == StLoad);
    assign busy      = (state_q == StLoad);
    assign done      = (state_q == StDone);
    assign hs        = s_valid & s_ready;
    assign bank_wrap = (bank_q == BankW'(ram_num - 1));
    // Final word of the fill: last bank at the last address row.
    assign last      = bank_wrap && ({1'b0, addr_q} == (len_q - LenW'(1)));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if (fill_len != '0) begin
                        state_d = StLoad;
                        len_d   = fill_len;
                        bank_d  = '0;
                        addr_d  = '0;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StLoad: begin
                if (hs) begin
                    if (bank_wrap) begin
                        bank_d = '0;
                        addr_d = addr_q + address'(1);
                    end else begin
                        bank_d = bank_q + BankW'(1);
                    end
                end
                if (abort) begin
                    state_d = StIdle;
                end else if (hs && last) begin
                    state_d = StDone;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            len_q   <= '0;
            bank_q  <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
        end
    end

    // Registered write port: unselected banks keep their last address/data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wen_q <= '0;
            for (int unsigned i = 0; i < ram_num; i++) begin
                addra[i] <= '0;
                dina[i]  <= '0;
            end
        end else begin
            wen_q <= '0;
            if (hs) begin
                wen_q[bank_q] <= 1'b1;
                addra[bank_q] <= addr_q;
                dina[bank_q]  <= s_data;
            end
        end
    end

    assign ena = wen_q;
    assign wea = wen_q;

`ifdef BANK_LOADER_OVF_EN
    logic ovf_q;

    // An accepted start clears the flag even if s_valid is high in that cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else if ((state_q == StIdle) && start) begin
            ovf_q <= 1'b0;
        end else if (s_valid && (state_q != StLoad)) begin
            ovf_q <= 1'b1;
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_bank_loader.sv
// Scoreboard bench for bank_loader: expected writes are queued as words are driven and
// popped by a write monitor; each scenario task also checks control outputs inline.
module tb_bank_loader;
    localparam int RN = 10;
    localparam int W  = 16;
    localparam int A  = 10;
`ifdef BANK_LOADER_OVF_EN
    localparam bit OvfEn = 1'b1;
`else
    localparam bit OvfEn = 1'b0;
`endif

    typedef struct {
        int bank;
        int addr;
        int data;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           start = 1'b0;
    logic           abort = 1'b0;
    logic [A:0]     fill_len = '0;
    logic           s_valid = 1'b0;
    logic           s_ready;
    logic [W-1:0]   s_data = '0;
    logic [RN-1:0]  ena;
    logic [RN-1:0]  wea;
    logic [A-1:0]   addra [0:RN-1];
    logic [W-1:0]   dina  [0:RN-1];
    logic           busy;
    logic           done;
    logic           ovf;

    int   checks = 0;
    int   failures = 0;
    int   writes = 0;
    int   done_cnt = 0;
    exp_t sb [$];

    bank_loader #(.ram_num(RN), .width(W), .address(A)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .fill_len(fill_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina),
        .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    // Write monitor: every write must match the head of the scoreboard.
    always @(negedge clk) begin
        int   b;
        exp_t e;
        if (rst && done) done_cnt++;
        if (rst && (ena !== '0 || wea !== '0)) begin
            checks++;
            b = -1;
            for (int i = 0; i < RN; i++) if (ena[i] === 1'b1) b = i;
            if (ena !== wea || $countones(ena) != 1) begin
                failures++;
                $display("FAIL write_onehot ena=%b wea=%b required one equal bit", ena, wea);
            end else if (sb.size() == 0) begin
                failures++;
                $display("FAIL write_unexpected bank=%0d addr=%0d data=%0d required none", b,
                         addra[b], dina[b]);
            end else begin
                e = sb.pop_front();
                writes++;
                if (b != e.bank || addra[b] !== A'(e.addr) || dina[b] !== W'(e.data)) begin
                    failures++;
                    $display("FAIL write_data got bank=%0d addr=%0d data=%0d exp bank=%0d addr=%0d data=%0d",
                             b, addra[b], dina[b], e.bank, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int bank, input int addr, input int data);
        exp_t e;
        e.bank = bank;
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if ({ena, wea, busy, done, s_ready, ovf} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0", {ena, wea, busy, done, s_ready, ovf});
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_release busy=%b s_ready=%b exp 0 0", busy, s_ready);
        end
    endtask

    task automatic test_back_to_back();
        int d0 = done_cnt;
        int w0 = writes;
        fill_len = 11'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_load busy=%b s_ready=%b exp 1 1", busy, s_ready);
        end
        for (int k = 0; k < 20; k++) begin
            s_valid = 1'b1;
            s_data = W'(k);
            // start inside LOAD must be ignored
            start = (k == 10);
            fill_len = (k == 10) ? 11'd0 : 11'd2;
            push(k % RN, k / RN, k);
            tick();
            start = 1'b0;
            if (k == 13) begin
                checks++;
                if (ena !== RN'(1 << 3) || addra[3] !== A'(1) || dina[3] !== W'(13)) begin
                    failures++;
                    $display("FAIL b2b_word13 ena=%b addr=%0d data=%0d exp ena bit3 addr=1 data=13",
                             ena, addra[3], dina[3]);
                end
            end
        end
        s_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || s_ready !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done done=%b s_ready=%b busy=%b exp 1 0 0", done, s_ready, busy);
        end
        tick();
        checks++;
        if (done !== 1'b0 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL b2b_after done=%b s_ready=%b exp 0 0", done, s_ready);
        end
        tick();
        tick();
        checks++;
        if (done_cnt - d0 != 1 || writes - w0 != 20 || sb.size() != 0) begin
            failures++;
            $display("FAIL b2b_counts dones=%0d writes=%0d pending=%0d exp 1 20 0",
                     done_cnt - d0, writes - w0, sb.size());
        end
        checks++;
        if (addra[3] !== A'(1) || dina[3] !== W'(13)) begin
            failures++;
            $display("FAIL b2b_hold addr=%0d data=%0d exp 1 13", addra[3], dina[3]);
        end
    endtask

    task automatic test_zero_len();
        int w0 = writes;
        fill_len = 11'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || s_ready !== 1'b0) begin
            failures++;
            $display("FAIL zero_done done=%b busy=%b s_ready=%b exp 1 0 0", done, busy, s_ready);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL zero_pulse done=%b exp 0", done);
        end
        tick();
        checks++;
        if (writes != w0) begin
            failures++;
            $display("FAIL zero_writes got=%0d exp=0", writes - w0);
        end
    endtask

    task automatic test_gaps();
        int w0 = writes;
        fill_len = 11'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            s_valid = (i % 2 == 0);
            s_data = W'(16'hA0 + i);
            if (i % 2 == 0) push(i / 2, 0, 16'hA0 + i);
            tick();
            checks++;
            if (ena !== ((i % 2 == 0) ? RN'(1 << (i / 2)) : RN'(0))) begin
                failures++;
                $display("FAIL gaps_ena%0d got=%b exp=%b", i, ena,
                         (i % 2 == 0) ? RN'(1 << (i / 2)) : RN'(0));
            end
        end
        s_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
        checks++;
        if (writes - w0 != 2 || busy !== 1'b0 || sb.size() != 0) begin
            failures++;
            $display("FAIL gaps_end writes=%0d busy=%b pending=%0d exp 2 0 0", writes - w0, busy,
                     sb.size());
        end
    endtask

    task automatic test_abort();
        int w0 = writes;
        int d0 = done_cnt;
        fill_len = 11'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            s_valid = 1'b1;
            s_data = W'(100 + k);
            abort = (k == 5);
            push(k, 0, 100 + k);
            tick();
        end
        s_valid = 1'b0;
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || s_ready !== 1'b0 || ena !== RN'(1 << 5)) begin
            failures++;
            $display("FAIL abort_state busy=%b done=%b s_ready=%b ena=%b exp 0 0 0 bit5", busy,
                     done, s_ready, ena);
        end
        tick();
        tick();
        checks++;
        if (writes - w0 != 6 || done_cnt != d0 || sb.size() != 0) begin
            failures++;
            $display("FAIL abort_counts writes=%0d dones=%0d pending=%0d exp 6 0 0", writes - w0,
                     done_cnt - d0, sb.size());
        end
    endtask

    task automatic test_reset_midfill();
        logic nz = 1'b0;
        int   d0 = done_cnt;
        fill_len = 11'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 7; k++) begin
            s_valid = 1'b1;
            s_data = W'(200 + k);
            push(k, 0, 200 + k);
            tick();
        end
        s_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        for (int i = 0; i < RN; i++) if (addra[i] !== '0 || dina[i] !== '0) nz = 1'b1;
        checks++;
        if ({ena, wea, busy, done, s_ready, ovf} !== '0 || nz) begin
            failures++;
            $display("FAIL rst_async ctl=%b arrays_nonzero=%b exp 0 0",
                     {ena, wea, busy, done, s_ready, ovf}, nz);
        end
        tick();
        tick();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done_cnt != d0 || sb.size() != 0) begin
            failures++;
            $display("FAIL rst_release busy=%b dones=%0d pending=%0d exp 0 0 0", busy,
                     done_cnt - d0, sb.size());
        end
        fill_len = 11'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        s_valid = 1'b1;
        s_data = W'(16'h55);
        push(0, 0, 16'h55);
        tick();
        s_valid = 1'b0;
        checks++;
        if (ena !== RN'(1) || addra[0] !== '0 || dina[0] !== W'(16'h55)) begin
            failures++;
            $display("FAIL rst_restart ena=%b addr=%0d data=%0d exp bit0 0 85", ena, addra[0],
                     dina[0]);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        tick();
    endtask

    task automatic test_ovf();
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        checks++;
        if (ovf !== OvfEn) begin
            failures++;
            $display("FAIL ovf_set got=%b exp=%b", ovf, OvfEn);
        end
        tick();
        tick();
        checks++;
        if (ovf !== OvfEn) begin
            failures++;
            $display("FAIL ovf_sticky got=%b exp=%b", ovf, OvfEn);
        end
        fill_len = 11'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (ovf !== 1'b0) begin
            failures++;
            $display("FAIL ovf_clear got=%b exp=0", ovf);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_zero_len();
        test_gaps();
        test_abort();
        test_reset_midfill();
        test_ovf();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout sim_time=%0t limit=200000", $time);
        $fatal(1);
    end

endmodule
